// File: rtl/exe_stage.sv
// Execute stage: ALU, store-data and branch resolution, plus a multi-cycle shift-add multiplier
// that freezes the pipeline while it runs. Define FORWARDING_EN to build the MEM/WB forwarding muxes.
module exe_stage #(
    parameter int MUL_BITS_PER_CYCLE = 1,
    parameter int BR_SHIFT           = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        wb_en,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  br,
    input  logic [3:0]  execute_cammand,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] reg2,
    input  logic [4:0]  dest,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic        mem_wb_en,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_value,
    input  logic        wb_wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic        wb_en_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [4:0]  dest_out,
    output logic        freeze_out
);

    localparam int RUN_CYCLES = 32 / MUL_BITS_PER_CYCLE;
    localparam logic [4:0] LAST_CNT = 5'(RUN_CYCLES - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_t;

    logic [31:0] op_a;
    logic [31:0] op_b;

`ifdef FORWARDING_EN
    // MEM is the younger producer, so it wins over WB; r0 is never forwarded.
    assign op_a = (src1 != 5'd0 && mem_wb_en && mem_dest == src1) ? mem_value :
                  (src1 != 5'd0 && wb_wb_en  && wb_dest  == src1) ? wb_value  : data1;
    assign op_b = (src2 != 5'd0 && mem_wb_en && mem_dest == src2) ? mem_value :
                  (src2 != 5'd0 && wb_wb_en  && wb_dest  == src2) ? wb_value  : data2;
    assign store_data = (src2 != 5'd0 && mem_wb_en && mem_dest == src2) ? mem_value :
                        (src2 != 5'd0 && wb_wb_en  && wb_dest  == src2) ? wb_value  : reg2;
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_wb_en, mem_dest, mem_value, wb_wb_en, wb_dest, wb_value, src1, src2};
    assign op_a       = data1;
    assign op_b       = data2;
    assign store_data = reg2;
`endif

    logic [31:0] alu_comb;

    always_comb begin
        // NOTE: default first so every path assigns alu_comb and no latch is inferred.
        alu_comb = '0;
        case (execute_cammand)
            OP_ADD:  alu_comb = op_a + op_b;
            OP_SUB:  alu_comb = op_a - op_b;
            OP_AND:  alu_comb = op_a & op_b;
            OP_OR:   alu_comb = op_a | op_b;
            OP_NOR:  alu_comb = ~(op_a | op_b);
            OP_XOR:  alu_comb = op_a ^ op_b;
            OP_SLL:  alu_comb = op_a << op_b[4:0];
            OP_SRA:  alu_comb = 32'($signed(op_a) >>> op_b[4:0]);
            OP_SRL:  alu_comb = op_a >> op_b[4:0];
            default: alu_comb = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (br)
            2'b01:   br_taken = (op_a == 32'd0);
            2'b10:   br_taken = (op_a != store_data);
            2'b11:   br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    assign br_addr = pc_in + (data2 << BR_SHIFT);

    mul_state_t  state_q, state_d;
    logic [31:0] mcand_q, mplier_q, acc_q;
    logic [4:0]  cnt_q;
    logic [31:0] partial;
    logic        is_mul;

    assign is_mul = (execute_cammand == OP_MUL);

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (is_mul) state_d = MUL_RUN;
            MUL_RUN:  if (cnt_q == LAST_CNT) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= MUL_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: the datapath registers are reset too, so an aborted multiply leaves no stale operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (is_mul) begin
                        mcand_q  <= op_a;
                        mplier_q <= op_b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                MUL_RUN: begin
                    acc_q    <= acc_q + partial;
                    mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Gating with rst drops the stall the instant reset asserts, even with a MUL still decoded.
    assign freeze_out = rst & (((state_q == MUL_IDLE) & is_mul) | (state_q == MUL_RUN));

    assign alu_result    = (state_q == MUL_DONE) ? acc_q : alu_comb;
    assign wb_en_out     = wb_en     & ~freeze_out;
    assign mem_read_out  = mem_read  & ~freeze_out;
    assign mem_write_out = mem_write & ~freeze_out;
    assign dest_out      = dest;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits directly downstream of the ID/EXE pipeline register and consumes its outputs.
- Computes the ALU result, store data and branch decision/target, with optional forwarding from the MEM and WB stages.
- A multi-cycle shift-add multiplier holds the pipeline via freeze_out while it runs. While frozen, the stage presents a bubble to the EXE/MEM register.

Parameters:
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4; RUN length = 32/MUL_BITS_PER_CYCLE cycles
BR_SHIFT, 2, left shift applied to data2 when forming the branch target

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pc_in  in  32  PC+4 of the instruction in EXE
wb_en  in  1  writeback enable from ID/EXE
mem_read  in  1  load flag
mem_write  in  1  store flag
br  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
execute_cammand  in  4  ALU opcode
data1  in  32  operand A (rs value)
data2  in  32  operand B (rt value or sign-extended immediate)
reg2  in  32  rt value (store data / BNE compare)
dest  in  5  destination register
src1  in  5  rs index
src2  in  5  rt index; ID drives 0 when data2 is an immediate
mem_wb_en  in  1  MEM-stage writeback enable
mem_dest  in  5  MEM-stage destination
mem_value  in  32  MEM-stage ALU result
wb_wb_en  in  1  WB-stage writeback enable
wb_dest  in  5  WB-stage destination
wb_value  in  32  WB-stage writeback value
alu_result  out  32  execute result
store_data  out  32  forwarded reg2
br_taken  out  1  branch/jump taken
br_addr  out  32  branch target
wb_en_out  out  1  wb_en gated by ~freeze_out
mem_read_out  out  1  mem_read gated by ~freeze_out
mem_write_out  out  1  mem_write gated by ~freeze_out
dest_out  out  5  dest passthrough
freeze_out  out  1  stall request to PC, IF/ID and ID/EXE registers

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR.
  - 6 SLL A<<B[4:0], 7 SRA A>>>B[4:0], 8 SRL A>>B[4:0].
  - 9 MUL (low 32 bits of A*B).
  - 10-15 produce 0.
- Arithmetic is modulo 2^32; there is no overflow flag.
- Forwarding (opA from src1, opB from src2, store_data from src2):
  - MEM match takes priority over WB match.
  - A match requires the stage's wb_en=1 and dest==src, with src≠0.
  - No forwarding for register 0.
  - src2==0 means data2 is used unmodified.
  - For opB the replaced value is data2. For store_data/BNE the replaced value is reg2.
- Branch:
  - br_addr = pc_in + (data2<<BR_SHIFT), wrapping.
  - BEZ taken iff opA==0; BNE taken iff opA≠store_data; JMP always taken; 00 never taken.
  - Combinational, same cycle.
- Non-MUL ops: combinational, zero added latency; freeze_out=0.
- MUL FSM states:
  - IDLE: execute_cammand==9 → capture opA/opB into multiplicand/multiplier, clear accumulator and counter, freeze_out=1, go RUN. Otherwise stay IDLE with freeze_out=0.
  - RUN: each cycle add shifted partial products for MUL_BITS_PER_CYCLE bits, freeze_out=1. When the counter reaches 32/MUL_BITS_PER_CYCLE-1, go DONE.
  - DONE: freeze_out=0, alu_result=accumulator. Go IDLE unconditionally on the next edge, when ID/EXE loads the next instruction.
- MUL timing: freeze_out is high for 1+32/MUL_BITS_PER_CYCLE cycles (33 at default). The result is presented exactly once, in DONE.
- MUL operands are captured in IDLE only. Forwarding sources that retire during the stall do not affect the result.
- A back-to-back MUL restarts from IDLE after DONE, with no result sharing.
- While freeze_out=1, alu_result is don't-care and downstream control is bubbled (wb_en_out=mem_read_out=mem_write_out=0).
- Reset (rst=0, any time, including mid-RUN):
  - FSM returns to IDLE; accumulator, operands and counter are cleared to 0.
  - freeze_out=0 immediately (asynchronous).
  - Combinational outputs follow the inputs.

Optional Feature:
FORWARDING_EN
- Defined: forwarding muxes are present as above.
- Undefined: opA=data1, opB=data2, store_data=reg2. mem_*/wb_* forwarding inputs are ignored and the hazard unit is responsible for stalls.

Test Plan:
- ADD data1=5, data2=7, src2=0 → alu_result=12, freeze_out=0; SUB 3-5 → 0xFFFFFFFE.
- MEM/WB both write r4 (mem_value=0x11, wb_value=0x22), src1=4, ADD data2=1, src2=0 → alu_result=0x12. Same stimulus with src1=0 → no forwarding. With FORWARDING_EN undefined → data1+1.
- MUL 0xFFFFFFFF*3 at default → freeze_out high 33 cycles, wb_en_out=0 throughout; DONE alu_result=0xFFFFFFFD; the instruction after the MUL flows normally.
- MUL 1234*5678 with MUL_BITS_PER_CYCLE=4 → freeze_out high 9 cycles, result 7006652.
- BNE with data1=r1 forwarded 9 from MEM, reg2=9, data2=-2, pc_in=0x40 → br_taken=0, br_addr=0x38. With reg2=8 → br_taken=1.
- Assert rst low mid-RUN (cycle 10 of a MUL) → freeze_out=0 immediately. After release, a new MUL 6*7 → 42 with full latency.
